// File: rtl/seg_p2s_tx.sv
// Serial 7-segment frame transmitter: captures a 4-digit hex value, encodes it
// active-low and clocks it into the board's shift chain. Optional macro SEG_P2S_DP_EN adds decimal points.
module seg_p2s_tx #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] num,
`ifdef SEG_P2S_DP_EN
    input  logic [3:0]  dp,
`endif
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        sdata,
    output logic        latch
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] div_cnt;
    logic          phase;
    logic [4:0]    bit_cnt;
    logic [30:0]   frame_rem;
    logic [31:0]   frame_enc;
    logic [3:0]    dp_v;

    function automatic logic [7:0] seg_enc(input logic [3:0] n, input logic dp_on);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return {~dp_on, s[6:0]};
    endfunction

`ifdef SEG_P2S_DP_EN
    assign dp_v = dp;
`else
    assign dp_v = 4'b0000;
`endif

    always_comb begin
        frame_enc = {seg_enc(num[15:12], dp_v[3]), seg_enc(num[11:8], dp_v[2]),
                     seg_enc(num[7:4],   dp_v[1]), seg_enc(num[3:0],  dp_v[0])};
    end

    // frame_rem holds the bits still to be sent; sdata always carries the current bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            div_cnt   <= '0;
            phase     <= 1'b0;
            bit_cnt   <= 5'd0;
            frame_rem <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            sdata     <= 1'b0;
            latch     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SHIFT;
                        frame_rem <= frame_enc[30:0];
                        sdata     <= frame_enc[31];
                        bit_cnt   <= 5'd31;
                        div_cnt   <= '0;
                        phase     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!phase) begin
                            phase <= 1'b1;
                            sclk  <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            sclk  <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                state <= S_LATCH;
                                sdata <= 1'b0;
                                latch <= 1'b1;
                            end else begin
                                bit_cnt   <= bit_cnt - 5'd1;
                                sdata     <= frame_rem[30];
                                frame_rem <= {frame_rem[29:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        latch   <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    sclk  <= 1'b0;
                    latch <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_p2s_tx.sv
// Scoreboard bench for seg_p2s_tx: the driver queues hand-computed frames,
// a monitor rebuilds each frame from sclk rising edges and checks it at done.
module tb_seg_p2s_tx;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] num;
`ifdef SEG_P2S_DP_EN
    logic [3:0]  dp;
`endif
    logic        start;
    logic        busy;
    logic        done;
    logic        sclk;
    logic        sdata;
    logic        latch;

    int total;
    int bad;
    logic [31:0] exp_q[$];

    logic [31:0] shreg;
    int nbits;
    int latch_len;
    int latch_pulses;
    int busy_len;
    int overlap;
    int done_cnt;
    int total_latch;
    logic prev_sclk;
    logic prev_latch;

    seg_p2s_tx #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
`ifdef SEG_P2S_DP_EN
        .dp    (dp),
`endif
        .start (start),
        .busy  (busy),
        .done  (done),
        .sclk  (sclk),
        .sdata (sdata),
        .latch (latch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        shreg        = '0;
        nbits        = 0;
        latch_len    = 0;
        latch_pulses = 0;
        busy_len     = 0;
        overlap      = 0;
    endtask

    // Monitor: rebuild the frame and per-transfer timing, compare at done.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            clear_mon();
            prev_sclk  = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (sclk && latch) overlap++;
            if (sclk && !prev_sclk) begin
                shreg = {shreg[30:0], sdata};
                nbits++;
            end
            if (latch) latch_len++;
            if (latch && !prev_latch) begin
                latch_pulses++;
                total_latch++;
            end
            if (busy) busy_len++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame", shreg, e);
                    check("sclk_edges", nbits, 32);
                    check("latch_len", latch_len, DIV);
                    check("latch_pulses", latch_pulses, 1);
                    check("busy_len", busy_len, 65 * DIV);
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    check("sclk_latch_overlap", overlap, 0);
                end
                clear_mon();
            end
            prev_sclk  = sclk;
            prev_latch = latch;
        end
    end

    task automatic send(input logic [15:0] n, input logic [31:0] exp);
        @(negedge clk);
        num   = n;
        start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        done_cnt    = 0;
        total_latch = 0;
        clear_mon();
        prev_sclk  = 1'b0;
        prev_latch = 1'b0;
        rst   = 1'b1;
        start = 1'b0;
        num   = 16'h0000;
`ifdef SEG_P2S_DP_EN
        dp    = 4'b0000;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_sclk",  {31'd0, sclk},  32'd0);
        check("rst_sdata", {31'd0, sdata}, 32'd0);
        check("rst_latch", {31'd0, latch}, 32'd0);
        rst = 1'b0;

        send(16'h0000, 32'hC0C0C0C0);
        wait_done(400);

        send(16'h1234, 32'hF9A4B099);
        repeat (20) @(negedge clk);
        num = 16'hFFFF;
        wait_done(400);

        send(16'hABCD, 32'h8883C6A1);
        wait_done(400);
        send(16'h8F0E, 32'h808EC086);
        wait_done(400);

        // start during bit 10 must be dropped, not queued
        send(16'h0F0F, 32'hC08EC08E);
        repeat (10 * 2 * DIV) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        repeat (300) @(negedge clk);
        check("ignored_start_done_cnt", done_cnt, 5);

        // start held high: two back-to-back frames with a one-cycle gap
        @(negedge clk);
        num   = 16'h2468;
        exp_q.push_back(32'hA4998280);
        exp_q.push_back(32'hA4998280);
        start = 1'b1;
        wait_done(400);
        @(negedge clk);
        check("b2b_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(400);

        // asynchronous reset during bit 17 aborts without a latch
        send(16'h1111, 32'hF9F9F9F9);
        repeat (17 * 2 * DIV + 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy",  {31'd0, busy},  32'd0);
        check("abort_sclk",  {31'd0, sclk},  32'd0);
        check("abort_sdata", {31'd0, sdata}, 32'd0);
        check("abort_latch", {31'd0, latch}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(16'h0001, 32'hC0C0C0F9);
        wait_done(400);

`ifdef SEG_P2S_DP_EN
        dp = 4'b0101;
        send(16'h0000, 32'hC040C040);
`else
        send(16'h0000, 32'hC0C0C0C0);
`endif
        wait_done(400);

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        check("final_done_cnt", done_cnt, 9);
        check("latch_per_done", total_latch, done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_p2s_tx.md
Name: seg_p2s_tx

Overview:
- Display-side consumer of the 4-digit hex value produced by the button/number-entry logic.
- On a start request, captures a 16-bit value and converts each nibble to an active-low 7-segment pattern.
- Serially shifts the 32-bit pattern stream into the LED board's external shift-register chain (SCLK/SDATA/LATCH), then pulses LATCH so the new digits appear.
- Sits between the number source and the board's P2S display pins.

Parameters:
- DIV, 4, clk cycles per SCLK half-period; legal range ≥1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- num  input  16  value to display; num[15:12] = leftmost digit (digit 3).
- start  input  1  request transfer; sampled only in IDLE.
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- sclk  output  1  serial clock to shift chain; idle low.
- sdata  output  1  serial data, MSB first.
- latch  output  1  storage-register latch strobe, active-high.

Behaviour:
- Reset (async, rst=1): state=IDLE; sclk=0, sdata=0, latch=0, busy=0, done=0; shift and divider counters cleared. Reset mid-transfer aborts immediately. No latch pulse is issued. The external display keeps its old contents.
- Segment encode, active-low, per byte {dp,g,f,e,d,c,b,a}, dp bit = 1 (off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
- Frame: 32 bits = {seg(num[15:12]), seg(num[11:8]), seg(num[7:4]), seg(num[3:0])}, sent bit 31 first.
- States: IDLE → SHIFT → LATCH → IDLE.
- IDLE: start=1 at a rising edge captures num into an internal frame register, loads the bit counter to 31, and enters SHIFT; busy=1 from the next cycle. Later changes on num do not affect the frame in flight.
- SHIFT, per bit:
  - sdata is driven with the current bit while sclk=0 for DIV cycles.
  - sclk=1 for DIV cycles; the external register samples on the sclk rising edge.
  - sdata is held stable across the whole bit period.
  - After bit 0's high phase, sclk returns to 0 and the state goes to LATCH.
  - Each bit lasts 2*DIV cycles.
- LATCH: latch=1 for DIV cycles with sclk=0 and sdata=0. Then go to IDLE with done=1 for exactly that one cycle and busy=0 in that same cycle.
- busy stays high for exactly 65*DIV cycles per transfer (260 at DIV=4).
- start while busy is ignored and not queued. start held high across done starts a new transfer on the first IDLE cycle after done.
- Exactly 32 sclk rising edges and 1 latch pulse occur per transfer.
- sclk and latch are never high together.
- sclk, sdata and latch are registered outputs (glitch-free).

Optional Feature:
- Macro SEG_P2S_DP_EN.
- Defined: adds input dp[3:0]. dp[i]=1 lights digit i's decimal point: byte bit7 = ~dp[i]. dp is captured together with num at start.
- Undefined: no dp port; bit7 of every byte is 1.
- Timing is identical in both builds.

Test Plan:
- Reset, then num=16'h0000, start pulse → 32 bits sampled on sclk rises = 32'hC0C0C0C0; one latch pulse of 4 cycles; busy high 260 cycles; single done pulse.
- num=16'h1234, start → stream 32'hF9A4B099. Change num to 16'hFFFF mid-transfer → stream unchanged.
- num=16'hABCD → 32'h8883C6A1. Then num=16'h8F0E → 32'h808EC086.
- start pulsed at bit 10 of a transfer → ignored: exactly 32 sclk edges and 1 latch in total. start held high continuously → back-to-back frames, each preceded by a 1-cycle IDLE/done gap.
- Assert rst at bit 17 → all outputs 0 within the same cycle, no latch. After release, a start with num=16'h0001 → clean 32'hC0C0C0F9 frame.
- With SEG_P2S_DP_EN, num=16'h0000, dp=4'b0101 → 32'hC040C040. Without the macro, same num → 32'hC0C0C0C0.
